regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_rdport.sv | 67 ++++++
 rtl/regfile_param.sv | 155 +++++++++++++++
 tb/tb_regfile_param.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parameterised register file.
package regfile_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

  // Select one byte lane: new data where enabled, old data otherwise.
  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              en
  );
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: range check, write-first bypass, rvalid.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      re,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  input  logic [WIDTH-1:0]          mem [DEPTH],
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [WIDTH/8-1:0]        wr_be,
  output logic [WIDTH-1:0]          rd,
  output logic                      rvalid,
  output logic                      oob_c
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NBYTE  = WIDTH / 8;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic             in_range;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             rvalid_q, rvalid_d;

  // Look up the word, merging any same-cycle write; out-of-range reads return 0.
  always_comb begin
    in_range = ({1'b0, raddr} < DEPTH_A);
    word     = '0;
    if (in_range) begin
      word = mem[raddr];
      if (wr_en && (wr_addr == raddr)) begin
        for (int b = 0; b < NBYTE; b++) begin
          word[BYTE_W*b +: BYTE_W] = merge_byte(word[BYTE_W*b +: BYTE_W],
                                                wr_data[BYTE_W*b +: BYTE_W], wr_be[b]);
        end
      end
    end
    oob_c    = re && !in_range;
    rd_d     = rd_q;
    rvalid_d = 1'b0;
    if (re) begin
      rd_d     = word;
      rvalid_d = 1'b1;
    end
  end

  // Read data / valid registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rd     = rd_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/regfile_param.sv
// Two-read, one-write register file with byte enables and a bulk-clear sweep.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]          wd,
  input  logic [WIDTH/8-1:0]        wbe,
  output logic                      wready,
  input  logic                      re0,
  input  logic [$clog2(DEPTH)-1:0]  raddr0,
  output logic [WIDTH-1:0]          rd0,
  output logic                      rvalid0,
  input  logic                      re1,
  input  logic [$clog2(DEPTH)-1:0]  raddr1,
  output logic [WIDTH-1:0]          rd1,
  output logic                      rvalid1,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      addr_err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NBYTE  = WIDTH / 8;
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic              addr_err_q, addr_err_d;

  logic              w_in_range;
  logic              wr_commit;
  logic              sweep;
  logic              u_en;
  logic [ADDR_W-1:0] u_addr;
  logic [WIDTH-1:0]  u_data;
  logic [NBYTE-1:0]  u_be;
  logic              oob0, oob1;

  assign wready = ~clr_busy_q;

  // Single update port shared by user writes and the clear sweep (never concurrent).
  always_comb begin
    w_in_range = ({1'b0, waddr} < DEPTH_A);
    wr_commit  = we && wready && w_in_range;
    sweep      = (state_q == CLR_RUN);
    u_en       = wr_commit || sweep;
    u_addr     = sweep ? idx_q : waddr;
    u_data     = sweep ? '0 : wd;
    u_be       = sweep ? '1 : wbe;
  end

  // Next memory contents after the byte-merged update.
  always_comb begin
    mem_d = mem_q;
    if (u_en) begin
      for (int b = 0; b < NBYTE; b++) begin
        mem_d[u_addr][BYTE_W*b +: BYTE_W] = merge_byte(mem_q[u_addr][BYTE_W*b +: BYTE_W],
                                                       u_data[BYTE_W*b +: BYTE_W], u_be[b]);
      end
    end
  end

  // Clear sequencer next state and its registered status outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d = CLR_RUN;
          idx_d   = '0;
        end
      end
      CLR_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = CLR_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
    clr_busy_d = (state_d != CLR_IDLE);
    clr_done_d = (state_d == CLR_DONE);
    addr_err_d = (we && wready && !w_in_range) || oob0 || oob1;
  end

  // Storage, sequencer and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q      <= '{default: '0};
      state_q    <= CLR_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign addr_err = addr_err_q;

  regfile_rdport #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rdport0 (
    .clk     (clk),
    .resetn  (resetn),
    .re      (re0),
    .raddr   (raddr0),
    .mem     (mem_q),
    .wr_en   (u_en),
    .wr_addr (u_addr),
    .wr_data (u_data),
    .wr_be   (u_be),
    .rd      (rd0),
    .rvalid  (rvalid0),
    .oob_c   (oob0)
  );

  regfile_rdport #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rdport1 (
    .clk     (clk),
    .resetn  (resetn),
    .re      (re1),
    .raddr   (raddr1),
    .mem     (mem_q),
    .wr_en   (u_en),
    .wr_addr (u_addr),
    .wr_data (u_data),
    .wr_be   (u_be),
    .rd      (rd1),
    .rvalid  (rvalid1),
    .oob_c   (oob1)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: DEPTH=8 instance for the main function, DEPTH=6 for range errors.
module tb_regfile_param;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  logic        we, re0, re1, clr_start;
  logic [2:0]  waddr, raddr0, raddr1;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic        wready, rvalid0, rvalid1, clr_busy, clr_done, addr_err;
  logic [31:0] rd0, rd1;

  logic        we6, re6;
  logic [2:0]  waddr6, raddr6;
  logic [31:0] wd6;
  logic        wready6, rvalid6, rvalid6b, busy6, done6, err6;
  logic [31:0] rd6, rd6b;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q6[$];

  always #5 clk = ~clk;

  regfile_param #(.DEPTH(8), .WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wd(wd), .wbe(wbe),
    .wready(wready), .re0(re0), .raddr0(raddr0), .rd0(rd0), .rvalid0(rvalid0),
    .re1(re1), .raddr1(raddr1), .rd1(rd1), .rvalid1(rvalid1),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .addr_err(addr_err)
  );

  regfile_param #(.DEPTH(6), .WIDTH(32)) dut6 (
    .clk(clk), .resetn(resetn), .we(we6), .waddr(waddr6), .wd(wd6), .wbe(4'hF),
    .wready(wready6), .re0(re6), .raddr0(raddr6), .rd0(rd6), .rvalid0(rvalid6),
    .re1(1'b0), .raddr1(3'd0), .rd1(rd6b), .rvalid1(rvalid6b),
    .clr_start(1'b0), .clr_busy(busy6), .clr_done(done6), .addr_err(err6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wd = d; wbe = be;
    tick();
    we = 1'b0;
  endtask

  // Monitor: pop the expected word whenever a port presents valid data.
  always @(negedge clk) begin
    if (rvalid0) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd0_unexpected: got rvalid0 with rd0=%h, no read pending", rd0);
      end else check("rd0", rd0, q0.pop_front());
    end
    if (rvalid1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd1_unexpected: got rvalid1 with rd1=%h, no read pending", rd1);
      end else check("rd1", rd1, q1.pop_front());
    end
    if (rvalid6) begin
      if (q6.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd6_unexpected: got rvalid with rd=%h, no read pending", rd6);
      end else check("rd6", rd6, q6.pop_front());
    end
    if (rvalid6b) begin
      n_chk++; n_fail++;
      $display("FAIL rd6b_unexpected: got rvalid1 on idle port, rd=%h", rd6b);
    end
  end

  initial begin
    we = 0; re0 = 0; re1 = 0; clr_start = 0;
    waddr = 0; raddr0 = 0; raddr1 = 0; wd = 0; wbe = 0;
    we6 = 0; re6 = 0; waddr6 = 0; raddr6 = 0; wd6 = 0;

    // Reset state
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd0", rd0, 32'h0);
    check("rst_rvalid0", {31'b0, rvalid0}, 32'h0);
    check("rst_rd1", rd1, 32'h0);
    check("rst_rvalid1", {31'b0, rvalid1}, 32'h0);
    check("rst_busy", {31'b0, clr_busy}, 32'h0);
    check("rst_done", {31'b0, clr_done}, 32'h0);
    check("rst_wready", {31'b0, wready}, 32'h1);
    check("rst_err", {31'b0, addr_err}, 32'h0);
    check("rst6_status", {26'b0, wready6, busy6, done6, err6, rvalid6, rvalid6b}, 32'h20);
    check("rst6_rd", rd6 | rd6b, 32'h0);
    resetn = 1'b1;
    tick();

    // Full write then read, 1-cycle latency, then hold with re=0
    wr8(3'd3, 32'hDEADBEEF, 4'hF);
    re0 = 1; raddr0 = 3'd3; q0.push_back(32'hDEADBEEF);
    tick();
    re0 = 0;
    tick();
    check("rvalid0_idle", {31'b0, rvalid0}, 32'h0);
    check("rd0_hold", rd0, 32'hDEADBEEF);

    // Partial byte write
    wr8(3'd3, 32'h11223344, 4'b0101);
    re1 = 1; raddr1 = 3'd3; q1.push_back(32'hDE22BE44);
    tick();
    re1 = 0;

    // Byte-merged bypass: write lanes 0,1 while reading same word
    we = 1; waddr = 3'd3; wd = 32'h0000AAAA; wbe = 4'b0011;
    re0 = 1; raddr0 = 3'd3; q0.push_back(32'hDE22AAAA);
    tick();
    // Full bypass on both ports
    we = 1; waddr = 3'd5; wd = 32'hCAFEF00D; wbe = 4'hF;
    re0 = 1; raddr0 = 3'd5; q0.push_back(32'hCAFEF00D);
    re1 = 1; raddr1 = 3'd5; q1.push_back(32'hCAFEF00D);
    tick();
    we = 0; re0 = 0; re1 = 0;

    // Fill all words nonzero
    for (int i = 0; i < 8; i++) wr8(3'(i), 32'h10000000 + i, 4'hF);

    // Clear with a same-cycle write, dropped writes and reads during the sweep
    clr_start = 1; we = 1; waddr = 3'd2; wd = 32'h77777777; wbe = 4'hF;
    tick();
    clr_start = 0;
    check("clr_busy_0", {31'b0, clr_busy}, 32'h1);
    check("clr_done_0", {31'b0, clr_done}, 32'h0);
    check("clr_wready_0", {31'b0, wready}, 32'h0);
    waddr = 3'd6; wd = 32'hFFFFFFFF;
    for (int j = 1; j <= 9; j++) begin
      re0 = (j == 2); raddr0 = 3'd0;
      re1 = (j == 2); raddr1 = 3'd7;
      if (j == 2) begin
        q0.push_back(32'h0);
        q1.push_back(32'h10000007);
      end
      clr_start = (j == 3);
      tick();
      check($sformatf("clr_busy_%0d", j), {31'b0, clr_busy}, (j < 9) ? 32'h1 : 32'h0);
      check($sformatf("clr_done_%0d", j), {31'b0, clr_done}, (j == 8) ? 32'h1 : 32'h0);
    end
    we = 0; re0 = 0; re1 = 0; clr_start = 0;
    tick();
    check("clr_after_busy", {31'b0, clr_busy}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      re0 = 1; raddr0 = 3'(i); q0.push_back(32'h0);
      tick();
    end
    re0 = 0;

    // Reset during the 4th cycle of a clear
    for (int i = 0; i < 8; i++) wr8(3'(i), 32'hA0A0A000 + i, 4'hF);
    clr_start = 1;
    tick();
    clr_start = 0;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("abort_busy", {31'b0, clr_busy}, 32'h0);
    check("abort_wready", {31'b0, wready}, 32'h1);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("abort_nodone_%0d", k), {30'b0, clr_busy, clr_done}, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      re1 = 1; raddr1 = 3'(i); q1.push_back(32'h0);
      tick();
    end
    re1 = 0;

    // Out-of-range accesses on DEPTH=6
    we6 = 1; waddr6 = 3'd1; wd6 = 32'hA5A5A5A5;
    tick();
    check("err6_inrange", {31'b0, err6}, 32'h0);
    waddr6 = 3'd7; wd6 = 32'h12345678;
    tick();
    we6 = 0;
    check("err6_wr_pulse", {31'b0, err6}, 32'h1);
    tick();
    check("err6_wr_clear", {31'b0, err6}, 32'h0);
    re6 = 1; raddr6 = 3'd7; q6.push_back(32'h0);
    tick();
    re6 = 0;
    check("err6_rd_pulse", {31'b0, err6}, 32'h1);
    tick();
    check("err6_rd_clear", {31'b0, err6}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      re6 = 1; raddr6 = 3'(i); q6.push_back((i == 1) ? 32'hA5A5A5A5 : 32'h0);
      tick();
    end
    re6 = 0;

    // Drain with a bound
    for (int k = 0; k < 20 && (q0.size() + q1.size() + q6.size()) != 0; k++) tick();
    tick();
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);
    check("q6_drained", 32'(q6.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
